// File: rtl/fmps_pkg.sv
// Shared definitions for the FMPS cell-controller link (transmit and receive sides).
package fmps_pkg;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hF5;

  localparam logic [1:0] ST_SENT      = 2'd0;
  localparam logic [1:0] ST_INHIBITED = 2'd1;
  localparam logic [1:0] ST_OVERRUN   = 2'd2;
  localparam logic [1:0] ST_STALL     = 2'd3;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_MAGIC_W   = 8;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_SEQ_W     = 8;
  localparam int HDR_EN_BIT    = 15;
  localparam int HDR_IDX_MAX_W = 15;

  localparam int PKT_WORDS = 3;

endpackage

// File: rtl/fmps_write_link.sv
// FMPS link transmitter: one 3-word AXI-Stream packet (header, data, check) per
// fast-acquisition strobe, plus per-strobe outcome reporting.
module fmps_write_link
  import fmps_pkg::*;
#(
  parameter int         INDEX_WIDTH  = 5,
  parameter logic [7:0] MAGIC        = MAGIC_DEFAULT,
  parameter int         STALL_CYCLES = 255,
  parameter string      dbg          = "false"
) (
  input  logic                   auClk,
  input  logic                   auReset,
  input  logic                   auFAstrobe,
  input  logic                   inhibit,
  input  logic [INDEX_WIDTH-1:0] fmpsIndex,
  input  logic                   fmpsEnabled,
  input  logic [31:0]            fmpsData,
  output logic                   TVALID,
  input  logic                   TREADY,
  output logic                   TLAST,
  output logic [31:0]            TDATA,
  output logic                   statusStrobe,
  output logic [1:0]             statusCode,
  output logic [7:0]             seqno,
  output logic [15:0]            packetCount
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DAT  = 2'd2;
  localparam logic [1:0] S_CHK  = 2'd3;

  localparam logic [15:0] STALL_LIM = 16'(STALL_CYCLES);

  (* mark_debug = dbg *) logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] hdr_q, hdr_d;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  seqno_q, seqno_d;
  logic [15:0] pkt_q, pkt_d;
  (* mark_debug = dbg *) logic [15:0] stall_q;
  logic [15:0] stall_d;
  logic        sts_stb_q, sts_stb_d;
  logic [1:0]  sts_code_q, sts_code_d;

  logic        busy, hs, last_hs, accept, overrun, stalling, stall_hit;
  logic [7:0]  seq_next;
  logic [31:0] chk_word;

  function automatic logic [31:0] make_hdr(input logic [7:0] seq, input logic en,
                                           input logic [INDEX_WIDTH-1:0] idx);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_LSB +: HDR_MAGIC_W] = MAGIC;
    h[HDR_SEQ_LSB +: HDR_SEQ_W]     = seq;
    h[HDR_EN_BIT]                   = en;
    h[INDEX_WIDTH-1:0]              = idx;
    return h;
  endfunction

  assign busy      = (state_q != S_IDLE);
  assign hs        = busy & TREADY;
  assign last_hs   = (state_q == S_CHK) & TREADY;
  // A strobe landing on the final handshake starts the next packet with no gap.
  assign accept    = auFAstrobe & (~busy | last_hs);
  assign overrun   = auFAstrobe & busy & ~last_hs;
  assign stalling  = busy & ~TREADY;
  assign stall_hit = stalling & (stall_q == STALL_LIM - 16'd1);
  assign seq_next  = last_hs ? seqno_q + 8'd1 : seqno_q;
  assign chk_word  = ~(hdr_q ^ dat_q);

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    dat_d      = dat_q;
    seqno_d    = seq_next;
    pkt_d      = last_hs ? pkt_q + 16'd1 : pkt_q;
    stall_d    = stall_q;
    sts_stb_d  = 1'b0;
    sts_code_d = sts_code_q;

    case (state_q)
      S_HDR:   if (TREADY) state_d = S_DAT;
      S_DAT:   if (TREADY) state_d = S_CHK;
      S_CHK:   if (TREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept && !inhibit) begin
      state_d = S_HDR;
      hdr_d   = make_hdr(seq_next, fmpsEnabled, fmpsIndex);
      dat_d   = fmpsData;
    end

    // Saturating count means the threshold is crossed only once per stall run.
    if (!busy || hs)
      stall_d = '0;
    else if (stall_q != STALL_LIM)
      stall_d = stall_q + 16'd1;

    if (overrun) begin
      sts_stb_d  = 1'b1;
      sts_code_d = ST_OVERRUN;
    end else if (last_hs) begin
      sts_stb_d  = 1'b1;
      sts_code_d = ST_SENT;
    end else if (stall_hit) begin
      sts_stb_d  = 1'b1;
      sts_code_d = ST_STALL;
    end else if (accept && inhibit) begin
      sts_stb_d  = 1'b1;
      sts_code_d = ST_INHIBITED;
    end
  end

  always_ff @(posedge auClk or posedge auReset) begin
    if (auReset) begin
      state_q    <= S_IDLE;
      hdr_q      <= '0;
      dat_q      <= '0;
      seqno_q    <= '0;
      pkt_q      <= '0;
      stall_q    <= '0;
      sts_stb_q  <= 1'b0;
      sts_code_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      dat_q      <= dat_d;
      seqno_q    <= seqno_d;
      pkt_q      <= pkt_d;
      stall_q    <= stall_d;
      sts_stb_q  <= sts_stb_d;
      sts_code_q <= sts_code_d;
    end
  end

  always_comb begin
    case (state_q)
      S_HDR:   TDATA = hdr_q;
      S_DAT:   TDATA = dat_q;
      S_CHK:   TDATA = chk_word;
      default: TDATA = '0;
    endcase
  end

  assign TVALID       = busy;
  assign TLAST        = (state_q == S_CHK);
  assign statusStrobe = sts_stb_q;
  assign statusCode   = sts_code_q;
  assign seqno        = seqno_q;
  assign packetCount  = pkt_q;

endmodule

// File: tb/tb_fmps_write_link.sv
// Bench for fmps_write_link: directed scenarios plus random traffic, all checked
// cycle by cycle against a packet-level reference model.
module tb_fmps_write_link;

  localparam int IW    = 5;
  localparam int STALL = 255;

  logic          auClk = 1'b0;
  logic          auReset = 1'b1;
  logic          auFAstrobe = 1'b0;
  logic          inhibit = 1'b0;
  logic [IW-1:0] fmpsIndex = '0;
  logic          fmpsEnabled = 1'b0;
  logic [31:0]   fmpsData = '0;
  logic          TREADY = 1'b0;
  logic          TVALID, TLAST, statusStrobe;
  logic [31:0]   TDATA;
  logic [1:0]    statusCode;
  logic [7:0]    seqno;
  logic [15:0]   packetCount;

  fmps_write_link #(
    .INDEX_WIDTH (IW),
    .MAGIC       (8'hF5),
    .STALL_CYCLES(STALL),
    .dbg         ("false")
  ) dut (
    .auClk       (auClk),
    .auReset     (auReset),
    .auFAstrobe  (auFAstrobe),
    .inhibit     (inhibit),
    .fmpsIndex   (fmpsIndex),
    .fmpsEnabled (fmpsEnabled),
    .fmpsData    (fmpsData),
    .TVALID      (TVALID),
    .TREADY      (TREADY),
    .TLAST       (TLAST),
    .TDATA       (TDATA),
    .statusStrobe(statusStrobe),
    .statusCode  (statusCode),
    .seqno       (seqno),
    .packetCount (packetCount)
  );

  always #5 auClk = ~auClk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the packet in flight, the running stall length and the pending report.
  bit          m_busy;
  int          m_widx;
  logic [31:0] m_w [3];
  logic [7:0]  m_seq;
  logic [15:0] m_cnt;
  int          m_run;
  bit          m_rep;
  bit          m_stb;
  logic [1:0]  m_code;

  function automatic void model_reset();
    m_busy = 0; m_widx = 0; m_seq = '0; m_cnt = '0;
    m_run = 0; m_rep = 0; m_stb = 0; m_code = '0;
    for (int i = 0; i < 3; i++) m_w[i] = '0;
  endfunction

  task automatic compare();
    check("tvalid", 32'(TVALID), 32'(m_busy));
    check("tlast", 32'(TLAST), 32'(m_busy && m_widx == 2));
    if (m_busy) check("tdata", TDATA, m_w[m_widx]);
    check("sstrobe", 32'(statusStrobe), 32'(m_stb));
    if (m_stb) check("scode", 32'(statusCode), 32'(m_code));
    check("seqno", 32'(seqno), 32'(m_seq));
    check("pktcount", 32'(packetCount), 32'(m_cnt));
  endtask

  task automatic model_step();
    bit hs, sent, ovr, acc, stall_ev;
    hs       = m_busy && TREADY;
    sent     = hs && (m_widx == 2);
    ovr      = auFAstrobe && m_busy && !sent;
    acc      = auFAstrobe && (!m_busy || sent);
    stall_ev = 0;
    if (m_busy && !TREADY) begin
      m_run++;
      if (m_run == STALL && !m_rep) begin
        stall_ev = 1;
        m_rep    = 1;
      end
    end else begin
      m_run = 0;
      m_rep = 0;
    end
    if (hs) begin
      if (m_widx == 2) m_busy = 0;
      else m_widx++;
    end
    if (sent) begin
      m_seq = m_seq + 8'd1;
      m_cnt = m_cnt + 16'd1;
    end
    if (acc && !inhibit) begin
      m_busy = 1;
      m_widx = 0;
      m_w[0] = {8'hF5, m_seq, fmpsEnabled, 10'b0, fmpsIndex};
      m_w[1] = fmpsData;
      m_w[2] = ~(m_w[0] ^ m_w[1]);
    end
    m_stb = 1;
    if (ovr) m_code = 2'd2;
    else if (sent) m_code = 2'd0;
    else if (stall_ev) m_code = 2'd3;
    else if (acc && inhibit) m_code = 2'd1;
    else m_stb = 0;
  endtask

  task automatic cycle();
    @(negedge auClk);
    compare();
    @(posedge auClk);
    model_step();
    #1;
  endtask

  task automatic strobe(input bit inh, input logic [IW-1:0] idx, input bit en,
                        input logic [31:0] data);
    auFAstrobe = 1'b1; inhibit = inh; fmpsIndex = idx; fmpsEnabled = en; fmpsData = data;
    cycle();
    auFAstrobe = 1'b0; inhibit = 1'b0;
    fmpsIndex = IW'($urandom); fmpsEnabled = 1'($urandom); fmpsData = $urandom;
  endtask

  initial begin
    model_reset();
    #2;
    compare();
    @(posedge auClk); @(posedge auClk); #1;
    auReset = 1'b0;

    // Basic packet with a ready sink.
    TREADY = 1'b1;
    strobe(0, 5'd5, 1, 32'h12345678);
    repeat (5) cycle();

    // Inhibited strobe.
    strobe(1, 5'd3, 1, 32'hDEADBEEF);
    repeat (3) cycle();

    // Long stall: TDATA must hold, one STALL report, then completion.
    TREADY = 1'b0;
    strobe(0, 5'd17, 0, 32'hA5A5_0F0F);
    repeat (300) cycle();
    TREADY = 1'b1;
    repeat (5) cycle();

    // Overrun during DAT, then back-to-back strobe on the CHK handshake.
    strobe(0, 5'd9, 1, 32'h0000_FFFF);
    cycle();
    strobe(0, 5'd1, 0, 32'h1111_1111);
    strobe(0, 5'd2, 1, 32'h2222_2222);
    repeat (5) cycle();

    // 256 chained packets to wrap the sequence number.
    strobe(0, IW'($urandom), 1'($urandom), $urandom);
    repeat (255) begin
      cycle();
      cycle();
      strobe(0, IW'($urandom), 1'($urandom), $urandom);
    end
    repeat (4) cycle();

    // Reset in the middle of DAT.
    strobe(0, 5'd7, 1, 32'hCAFE_F00D);
    cycle();
    auReset = 1'b1;
    #1;
    check("rst_tvalid", 32'(TVALID), 32'd0);
    check("rst_seqno", 32'(seqno), 32'd0);
    check("rst_pktcount", 32'(packetCount), 32'd0);
    model_reset();
    @(posedge auClk); #1;
    auReset = 1'b0;
    strobe(0, 5'd4, 1, 32'h0BAD_F00D);
    repeat (5) cycle();

    // Overrun strobe on the cycle the stall threshold is reached.
    TREADY = 1'b0;
    strobe(0, 5'd12, 1, 32'h7777_0000);
    repeat (STALL - 1) cycle();
    strobe(0, 5'd13, 0, 32'h8888_0000);
    repeat (3) cycle();
    TREADY = 1'b1;
    repeat (5) cycle();

    // Random traffic.
    repeat (3000) begin
      auFAstrobe  = ($urandom_range(0, 5) == 0);
      inhibit     = ($urandom_range(0, 3) == 0);
      TREADY      = ($urandom_range(0, 3) != 0);
      fmpsIndex   = IW'($urandom);
      fmpsEnabled = 1'($urandom);
      fmpsData    = $urandom;
      cycle();
    end
    auFAstrobe = 1'b0;
    TREADY = 1'b1;
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
